// File: rtl/parallel_data_receiver.sv
// parallel_data_receiver: takes words in over a 4-phase req/ack handshake, queues them in a FIFO and hands them on over valid/ready; PDR_PARITY_CHECK_EN adds a sticky even-parity error flag
module parallel_data_receiver #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
`ifdef PDR_PARITY_CHECK_EN
  input  logic             parity_in,
  output logic             parity_err,
`endif
  output logic [CNT_W-1:0] word_cnt
);
  typedef enum logic {IDLE, ACK} state_e;
  state_e           state_q, state_d;
  logic             ack_q, out_valid_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_out_q, head_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_nx;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] word_cnt_q;
  logic             wr, rd;
`ifdef PDR_PARITY_CHECK_EN
  logic             parity_err_q;
  assign parity_err = parity_err_q;
`endif
  assign ack       = ack_q;
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign word_cnt  = word_cnt_q;
  // capture/read decisions use pre-edge level; head register tracks the word that will sit at the FIFO head after the edge
  always_comb begin
    wr      = state_q == IDLE && req && level_q != LW'(DEPTH);
    rd      = out_valid_q && out_ready;
    rd_nx   = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(wr) - LW'(rd);
    state_d = wr ? ACK : (state_q == ACK && !req) ? IDLE : state_q;
    head_d  = (rd && level_q > LW'(1)) ? mem_q[rd_nx] :
              (wr && level_q == LW'(rd)) ? data_in : data_out_q;
  end
  // handshake FSM, FIFO storage and counters, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      level_q     <= '0;
      word_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef PDR_PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ack_q       <= state_d == ACK;
      level_q     <= level_d;
      out_valid_q <= level_d != '0;
      data_out_q  <= head_d;
      if (wr) begin
        mem_q[wr_ptr_q] <= data_in;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
        word_cnt_q      <= word_cnt_q + CNT_W'(1);
      end
      if (rd) rd_ptr_q <= rd_nx;
`ifdef PDR_PARITY_CHECK_EN
      if (wr && ^{data_in, parity_in}) parity_err_q <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_parallel_data_receiver.sv
// tb_parallel_data_receiver: directed handshake scenarios plus a random run, output words checked by a queue-based scoreboard
module tb_parallel_data_receiver;
  logic       clk = 1'b0, rst_n = 1'b0, req = 1'b0, out_ready = 1'b0;
  logic [3:0] data_in = '0;
  logic       ack, out_valid;
  logic [3:0] data_out;
  logic [1:0] level;
  logic [7:0] word_cnt;
`ifdef PDR_PARITY_CHECK_EN
  logic       parity_in = 1'b0;
  logic       parity_err;
`endif
  logic [3:0] exp_q [$];
  int         checks = 0, errors = 0, cnt = 0;
  bit         rdy_rand = 1'b0, bad_par = 1'b0;
  logic       rdy_force = 1'b0;

  parallel_data_receiver dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .ack(ack),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .level(level),
`ifdef PDR_PARITY_CHECK_EN
    .parity_in(parity_in), .parity_err(parity_err),
`endif
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic v, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== v && n < 300);
    chk(nm, ack, v);
  endtask

  // one complete 4-phase handshake; the word is expected downstream in issue order
  task automatic send(input logic [3:0] d);
    tick(1);
    req = 1'b1;
    data_in = d;
`ifdef PDR_PARITY_CHECK_EN
    parity_in = ^d ^ bad_par;
`endif
    exp_q.push_back(d);
    wait_ack(1'b1, "ack_up");
    cnt++;
    chk("word_cnt", word_cnt, cnt % 256);
    req = 1'b0;
    wait_ack(1'b0, "ack_dn");
  endtask

  // consumer side: drives out_ready and scores every accepted word against the queue
  initial forever begin
    @(negedge clk);
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_empty act=%0h exp=none", data_out);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL mon_data act=%0h exp=%0h", data_out, e);
        end
      end
    end
  end

  initial begin
    req = 1'b1;
    data_in = 4'hA;
    tick(3);
    chk("rst_ack", ack, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_dout", data_out, 0);
    exp_q.push_back(4'hA);
    rst_n = 1'b1;
    wait_ack(1'b1, "t1_ack");
    cnt = 1;
    chk("t1_cnt", word_cnt, 1);
    chk("t1_dout", data_out, 4'hA);
    req = 1'b0;
    wait_ack(1'b0, "t1_ack_dn");
    tick(1);
    rdy_force = 1'b1;
    tick(3);
    rdy_force = 1'b0;
    chk("t1_drain", level, 0);
    send(4'h5);
    chk("t2_valid", out_valid, 1);
    chk("t2_dout", data_out, 4'h5);
    chk("t2_level", level, 1);
    tick(1);
    rdy_force = 1'b1;
    tick(3);
    rdy_force = 1'b0;
    send(4'h1);
    send(4'h2);
    chk("t3_full", level, 2);
    tick(1);
    req = 1'b1;
    data_in = 4'h3;
`ifdef PDR_PARITY_CHECK_EN
    parity_in = ^data_in;
`endif
    exp_q.push_back(4'h3);
    repeat (4) begin
      @(negedge clk);
      chk("t3_stall", ack, 0);
    end
    tick(1);
    rdy_force = 1'b1;
    wait_ack(1'b1, "t3_ack");
    cnt++;
    chk("t3_cnt", word_cnt, cnt % 256);
    req = 1'b0;
    wait_ack(1'b0, "t3_ack_dn");
    tick(4);
    rdy_force = 1'b0;
    chk("t3_drain", level, 0);
    send(4'h7);
    chk("t4_pre_level", level, 1);
    chk("t4_pre_dout", data_out, 4'h7);
    tick(1);
    rdy_force = 1'b1;
    req = 1'b1;
    data_in = 4'h8;
`ifdef PDR_PARITY_CHECK_EN
    parity_in = ^data_in;
`endif
    exp_q.push_back(4'h8);
    wait_ack(1'b1, "t4_ack");
    cnt++;
    chk("t4_level", level, 1);
    chk("t4_dout", data_out, 4'h8);
    req = 1'b0;
    wait_ack(1'b0, "t4_ack_dn");
    tick(3);
    rdy_force = 1'b0;
    chk("t4_drain", level, 0);
    tick(1);
    req = 1'b1;
    data_in = 4'h9;
`ifdef PDR_PARITY_CHECK_EN
    parity_in = ^data_in;
`endif
    exp_q.push_back(4'h9);
    wait_ack(1'b1, "mr_ack");
    rst_n = 1'b0;
    #1;
    chk("mr_ack0", ack, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_level", level, 0);
    chk("mr_cnt", word_cnt, 0);
    exp_q.delete();
    cnt = 0;
    tick(1);
    exp_q.push_back(4'h9);
    rst_n = 1'b1;
    wait_ack(1'b1, "mr_reack");
    cnt = 1;
    chk("mr_cnt1", word_cnt, 1);
    chk("mr_dout", data_out, 4'h9);
    req = 1'b0;
    wait_ack(1'b0, "mr_ack_dn");
    rdy_rand = 1'b1;
    repeat (255) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(4'($urandom));
    end
    chk("wrap_cnt", word_cnt, 0);
`ifdef PDR_PARITY_CHECK_EN
    chk("par_clean", parity_err, 0);
    bad_par = 1'b1;
    send(4'h3);
    bad_par = 1'b0;
    chk("par_err", parity_err, 1);
    send(4'h4);
    chk("par_sticky", parity_err, 1);
`endif
    tick(1);
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    tick(8);
    chk("end_level", level, 0);
    chk("end_valid", out_valid, 0);
    chk("end_queue", exp_q.size(), 0);
`ifdef PDR_PARITY_CHECK_EN
    rst_n = 1'b0;
    #1;
    chk("par_rst", parity_err, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
